// File: rtl/nios_system_sqrt_operand.sv
// rtl/nios_system_sqrt_operand.sv - Avalon-MM operand/start register block for the sqrt coprocessor
module nios_system_sqrt_operand #(
    parameter logic [31:0] RESET_OPERAND = 32'h0000_0000,
    parameter int          CNT_WIDTH     = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [31:0] out_port,
    output logic        start_out,
    input  logic        done_in,
    output logic        irq
);

    localparam logic [1:0] ADDR_OPERAND = 2'd0;
    localparam logic [1:0] ADDR_CONTROL = 2'd1;
    localparam logic [1:0] ADDR_STATUS  = 2'd2;
    localparam logic [1:0] ADDR_CYCLES  = 2'd3;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [31:0]          operand_q, operand_d;
    logic [31:0]          readdata_q, readdata_d;
    logic                 start_q, start_d;
    logic                 irq_q, irq_d;
    logic                 busy_q, busy_d;
    logic                 done_flag_q, done_flag_d;
    logic                 overrun_q, overrun_d;
    logic                 irq_en_q, irq_en_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 done_q, done_d;

    logic wr_en;
    logic operand_wr;
    logic start_req;
    logic start_acc;
    logic done_rise;
    logic done_clr;
    logic overrun_clr;
    logic overrun_set;

    // Decode bus writes, detect the done edge and compute every next-state value
    always_comb begin
        wr_en       = chipselect & ~write_n;
        operand_wr  = wr_en && (address == ADDR_OPERAND);
        start_req   = wr_en && (address == ADDR_CONTROL) && writedata[0];
        // Only the registered busy decides acceptance, so a start landing on a done edge is refused
        start_acc   = start_req & ~busy_q;
        done_rise   = done_in & ~done_q;
        done_clr    = wr_en && (address == ADDR_STATUS) && writedata[1];
        overrun_clr = wr_en && (address == ADDR_STATUS) && writedata[2];
        overrun_set = (start_req | operand_wr) & busy_q;

        operand_d   = operand_q;
        irq_en_d    = irq_en_q;
        busy_d      = busy_q;
        done_flag_d = done_flag_q;
        overrun_d   = overrun_q;
        cnt_d       = cnt_q;
        done_d      = done_in;
        start_d     = start_acc;
        // irq lags done/irq_en by one cycle because it is built from registered state
        irq_d       = done_flag_q & irq_en_q;

        // The operand is frozen while the coprocessor is working on it
        if (operand_wr && !busy_q) begin
            operand_d = writedata;
        end

        if (wr_en && (address == ADDR_CONTROL)) begin
            irq_en_d = writedata[1];
        end

        // Sticky overrun: a new set beats a simultaneous clear
        if (overrun_set) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end

        if (start_acc) begin
            busy_d      = 1'b1;
            done_flag_d = 1'b0;
            cnt_d       = '0;
        end else begin
            if (done_rise && busy_q) begin
                busy_d      = 1'b0;
                done_flag_d = 1'b1;
            end else if (done_clr) begin
                done_flag_d = 1'b0;
            end
            // Counts every cycle busy is registered high, including the finishing edge
            if (busy_q && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        readdata_d = 32'h0;
        if (chipselect) begin
            case (address)
                ADDR_OPERAND: readdata_d = operand_q;
                ADDR_CONTROL: readdata_d = {30'h0, irq_en_q, 1'b0};
                ADDR_STATUS:  readdata_d = {29'h0, overrun_q, done_flag_q, busy_q};
                ADDR_CYCLES:  readdata_d = 32'(cnt_q);
                default:      readdata_d = 32'h0;
            endcase
        end
    end

    // All block state, cleared asynchronously by reset_n
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            operand_q   <= RESET_OPERAND;
            readdata_q  <= 32'h0;
            start_q     <= 1'b0;
            irq_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_flag_q <= 1'b0;
            overrun_q   <= 1'b0;
            irq_en_q    <= 1'b0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            operand_q   <= operand_d;
            readdata_q  <= readdata_d;
            start_q     <= start_d;
            irq_q       <= irq_d;
            busy_q      <= busy_d;
            done_flag_q <= done_flag_d;
            overrun_q   <= overrun_d;
            irq_en_q    <= irq_en_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
        end
    end

    assign readdata  = readdata_q;
    assign out_port  = operand_q;
    assign start_out = start_q;
    assign irq       = irq_q;

endmodule

// File: doc/nios_system_sqrt_operand.md
# nios_system_sqrt_operand

Avalon-MM slave that is the write side of the square-root coprocessor interface: the Nios writes the operand and a start command here, and the block drives the coprocessor operand bus and a one-cycle start strobe. It tracks busy/done state from the coprocessor's done strobe, counts operation latency, and raises a level interrupt on completion. The 32-bit result is read back through the separate read-only result port.

## Interface
- `RESET_OPERAND`, 32'h0000_0000, reset value of the operand register and `out_port`
- `CNT_WIDTH`, 16, width of the latency counter (1..32)

- `clk`  in  1  system clock
- `reset_n`  in  1  asynchronous, active-low reset
- `address`  in  2  register select
- `chipselect`  in  1  slave select
- `write_n`  in  1  active-low write strobe; a write occurs when `chipselect`=1 and `write_n`=0
- `writedata`  in  32  write data
- `readdata`  out  32  registered read data
- `out_port`  out  32  operand to the coprocessor, equal to the OPERAND register
- `start_out`  out  1  one-cycle start pulse to the coprocessor
- `done_in`  in  1  coprocessor completion; the rising edge is used
- `irq`  out  1  level interrupt: `done & irq_en`

## Operation
- Register map:
  - Address 0, OPERAND (RW, 32 bits). A write is ignored while busy=1 and sets overrun.
  - Address 1, CONTROL. Writing bit0=1 requests a start. Bit1 is irq_en (RW). Reads return {30'b0, irq_en, 1'b0}.
  - Address 2, STATUS. Bit0 busy (RO). Bit1 done (sticky, W1C). Bit2 overrun (sticky, W1C). Upper bits read 0.
  - Address 3, CYCLES (RO). Zero-extended latency counter.
- Start request accepted when busy=0:
  - `start_out`=1 for exactly the next cycle.
  - busy←1, done←0, counter←0.
- Start request rejected when busy=1: no pulse; overrun←1.
- Edge detection: `done_in` is registered into `done_q`; a rising edge is `done_in & ~done_q`.
- Rising edge while busy=1: busy←0, done←1, counter frozen.
- Rising edge while busy=0: ignored, no state change.
- Counter:
  - Increments every cycle while busy=1, including the `start_out` cycle.
  - Saturates at 2^CNT_WIDTH−1.
  - Holds its value while idle.
- Simultaneous events:
  - Done-edge set and W1C clear of done in the same cycle: set wins, done=1.
  - Start write in the same cycle as a done edge: the registered busy (=1) governs, so the start is rejected and overrun←1.
  - Overrun set and W1C clear in the same cycle: set wins.
- Writes to RO bits and RO addresses have no effect.

## Timing
- Reset values (asynchronous): `readdata`=0, `out_port`=RESET_OPERAND, `start_out`=0, `irq`=0, busy=0, done=0, overrun=0, irq_en=0, counter=0, `done_q`=0.
- Read latency:
  - `readdata` is updated on every clock edge from the mux of `address`, so the value is valid one cycle after `address` is presented.
  - `readdata` is zeroed when `chipselect`=0.
- Write path:
  - OPERAND write: `out_port` changes at the write edge.
  - CONTROL start write at edge N: `start_out` is high during cycle N+1, busy=1 from N+1.
- Done path:
  - `done_in` rising during cycle M: busy=0 and done=1 after edge M.
  - `irq` is registered and asserts the cycle after done=1 when irq_en=1.
  - `irq` deasserts the cycle after done is cleared or irq_en is cleared.
- Reset asserted mid-operation: all state clears immediately and `start_out` drops. A later `done_in` edge with busy=0 is ignored.

## Test plan
1. Reset: all outputs at reset values; reads of addresses 0–3 return 0 with RESET_OPERAND=0.
2. Normal operation:
   - Stimulus: write OPERAND=0x0000_0190, write CONTROL=0x3, coprocessor raises `done_in` 10 cycles after `start_out`.
   - Required: `out_port`=0x190; exactly one `start_out` pulse; STATUS=0x2 after done; CYCLES=11; `irq`=1.
   - Then write STATUS=0x2: done clears and `irq` falls.
3. Start while busy:
   - Stimulus: a second CONTROL=0x1 write and an OPERAND=0xFFFF write mid-operation.
   - Required: no second `start_out`; `out_port` unchanged; STATUS bit2=1.
   - Then write STATUS=0x4: overrun clears.
4. Spurious `done_in` edge while idle: STATUS stays 0x0, `irq` stays 0, CYCLES unchanged.
5. Saturation with CNT_WIDTH=4: hold `done_in` low for 40 cycles after start; CYCLES reads 0xF.
6. Reset mid-operation: assert `reset_n`=0 while busy; STATUS=0 and `start_out`=0; a subsequent `done_in` edge leaves done=0.
